// File: rtl/osc_freq_meter.sv
// osc_freq_meter
// Counts rising edges of an asynchronous oscillator output over a fixed gate
// window of fpga_clk_i cycles. It reports the count once per window, with a
// one-cycle valid pulse and a flag that marks a saturated count. The
// oscillator is handled as data: it is synchronised and edge-detected in the
// single fpga_clk_i domain.

module osc_freq_meter #(
    parameter int GATE_CYCLES = 100000,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   fpga_clk_i,
    input  logic                   rstn_i,
    input  logic                   enable_i,
    input  logic                   osc_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   valid_o,
    output logic                   overflow_o,
    output logic                   busy_o
);

    localparam int TIMER_WIDTH = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_GATE
    } state_t;

    state_t                 state;
    logic [TIMER_WIDTH-1:0] timer;
    logic [COUNT_WIDTH-1:0] edge_count;
    logic                   sat;

    logic                   s1;
    logic                   s2;
    logic                   s3;
    logic                   rise;
    logic                   terminal;
    logic [COUNT_WIDTH-1:0] edge_count_inc;
    logic                   sat_inc;

    // Two-flop synchroniser plus history flop; runs in every state so that a
    // level already present when measuring starts is never seen as an edge.
    always_ff @(posedge fpga_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= osc_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign terminal = (timer == TIMER_LAST);

    // Edge count after this cycle's rise, held at the ceiling once saturated.
    always_comb begin
        edge_count_inc = edge_count;
        sat_inc        = sat;
        if (rise) begin
            if (edge_count == COUNT_MAX) begin
                sat_inc = 1'b1;
            end else begin
                edge_count_inc = edge_count + 1'b1;
            end
        end
    end

    // Measurement FSM: gate timer, edge counter, result registers and busy.
    always_ff @(posedge fpga_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= ST_IDLE;
            timer      <= '0;
            edge_count <= '0;
            sat        <= 1'b0;
            count_o    <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    timer      <= '0;
                    edge_count <= '0;
                    sat        <= 1'b0;
                    if (enable_i) begin
                        state  <= ST_ARM;
                        busy_o <= 1'b1;
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                ST_ARM: begin
                    timer      <= '0;
                    edge_count <= '0;
                    sat        <= 1'b0;
                    if (enable_i) begin
                        state  <= ST_GATE;
                        busy_o <= 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                ST_GATE: begin
                    if (terminal) begin
                        count_o    <= edge_count_inc;
                        overflow_o <= sat_inc;
                        valid_o    <= 1'b1;
                        timer      <= '0;
                        edge_count <= '0;
                        sat        <= 1'b0;
                        if (enable_i) begin
                            busy_o <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end
                    end else if (!enable_i) begin
                        state      <= ST_IDLE;
                        busy_o     <= 1'b0;
                        timer      <= '0;
                        edge_count <= '0;
                        sat        <= 1'b0;
                    end else begin
                        timer      <= timer + 1'b1;
                        edge_count <= edge_count_inc;
                        sat        <= sat_inc;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    busy_o     <= 1'b0;
                    timer      <= '0;
                    edge_count <= '0;
                    sat        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osc_freq_meter.sv
// Testbench for osc_freq_meter: a 16-bit and a 4-bit instance share stimulus.
// Expected window results are queued as stimulus is planned and compared
// against the results the DUT reports.

module tb_osc_freq_meter;

    localparam int GATE = 100;

    typedef struct {
        logic [15:0] count;
        logic        ovf;
        int          cyc;
    } obs_t;

    typedef struct {
        logic [15:0] count;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rstn_i;
    logic        enable_i;
    logic        osc_i;
    logic [15:0] count16;
    logic        valid16;
    logic        ovf16;
    logic        busy16;
    logic [3:0]  count4;
    logic        valid4;
    logic        ovf4;
    logic        busy4;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   osc_period = 0;
    int   osc_phase  = 0;
    logic osc_level  = 1'b0;

    obs_t obs16_q[$];
    obs_t obs4_q[$];
    exp_t exp16_q[$];
    exp_t exp4_q[$];

    osc_freq_meter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(16)) dut (
        .fpga_clk_i (clk),
        .rstn_i     (rstn_i),
        .enable_i   (enable_i),
        .osc_i      (osc_i),
        .count_o    (count16),
        .valid_o    (valid16),
        .overflow_o (ovf16),
        .busy_o     (busy16)
    );

    osc_freq_meter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(4)) dut4 (
        .fpga_clk_i (clk),
        .rstn_i     (rstn_i),
        .enable_i   (enable_i),
        .osc_i      (osc_i),
        .count_o    (count4),
        .valid_o    (valid4),
        .overflow_o (ovf4),
        .busy_o     (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge: update the oscillator and log results.
    task automatic tick();
        obs_t o;
        @(negedge clk);
        cyc++;
        if (osc_period != 0) begin
            osc_phase = (osc_phase + 1) % osc_period;
            osc_i = (osc_phase < osc_period / 2);
        end else begin
            osc_i = osc_level;
        end
        if (valid16 === 1'b1) begin
            o.count = count16;
            o.ovf   = ovf16;
            o.cyc   = cyc;
            obs16_q.push_back(o);
        end
        if (valid4 === 1'b1) begin
            o.count = {12'd0, count4};
            o.ovf   = ovf4;
            o.cyc   = cyc;
            obs4_q.push_back(o);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_obs16(input int budget, output bit ok);
        int n = 0;
        while (obs16_q.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        ok = (obs16_q.size() != 0);
    endtask

    task automatic wait_obs4(input int budget, output bit ok);
        int n = 0;
        while (obs4_q.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        ok = (obs4_q.size() != 0);
    endtask

    task automatic clear_queues();
        obs16_q.delete();
        obs4_q.delete();
        exp16_q.delete();
        exp4_q.delete();
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rstn_i   = 1'b0;
        enable_i = 1'b0;
        osc_i    = 1'b0;
        ticks(3);
        n_checks++;
        if (count16 !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count16); end
        n_checks++;
        if (valid16 !== 1'b0 || ovf16 !== 1'b0 || busy16 !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_flags: got v=%b o=%b b=%b expected 000", valid16, ovf16, busy16);
        end
        n_checks++;
        if (count4 !== 4'd0 || ovf4 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_count4: got %0d/%b expected 0/0", count4, ovf4); end
        rstn_i = 1'b1;
        ticks(10);
        n_checks++;
        if (busy16 !== 1'b0 || obs16_q.size() != 0) begin
            n_fail++; $display("[TB] FAIL idle_quiet: got busy=%b results=%0d expected 0/0", busy16, obs16_q.size());
        end
    endtask

    task automatic test_nominal();
        bit ok;
        obs_t o;
        exp_t e;
        int c0;
        $display("[TB] test_nominal");
        clear_queues();
        osc_period = 10;
        osc_phase  = 0;
        ticks(2);
        enable_i = 1'b1;
        c0 = cyc;
        for (int w = 0; w < 3; w++) exp16_q.push_back('{16'd10, 1'b0});
        for (int w = 0; w < 3; w++) begin
            e = exp16_q.pop_front();
            wait_obs16(150, ok);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("[TB] FAIL nominal_timeout: got no result expected window %0d", w);
            end else begin
                o = obs16_q.pop_front();
                n_checks++;
                if (o.count !== e.count || o.ovf !== e.ovf) begin
                    n_fail++; $display("[TB] FAIL nominal_count: got %0d/%b expected %0d/%b", o.count, o.ovf, e.count, e.ovf);
                end
                n_checks++;
                if (o.cyc != c0 + GATE + 2 + GATE * w) begin
                    n_fail++; $display("[TB] FAIL nominal_timing: got cycle %0d expected %0d", o.cyc, c0 + GATE + 2 + GATE * w);
                end
            end
        end
        enable_i = 1'b0;
        ticks(5);
        n_checks++;
        if (busy16 !== 1'b0) begin n_fail++; $display("[TB] FAIL nominal_busy_off: got %b expected 0", busy16); end
    endtask

    task automatic test_saturation();
        bit ok;
        obs_t o;
        exp_t e;
        int c0;
        $display("[TB] test_saturation");
        clear_queues();
        osc_period = 4;
        osc_phase  = 0;
        ticks(2);
        enable_i = 1'b1;
        c0 = cyc;
        exp4_q.push_back('{16'd15, 1'b1});
        exp4_q.push_back('{16'd0, 1'b0});
        exp16_q.push_back('{16'd0, 1'b0});
        while (cyc < c0 + 80) tick();
        osc_period = 0;
        osc_level  = 1'b0;
        for (int w = 0; w < 2; w++) begin
            e = exp4_q.pop_front();
            wait_obs4(150, ok);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("[TB] FAIL sat_timeout: got no result expected window %0d", w);
            end else begin
                o = obs4_q.pop_front();
                n_checks++;
                if (o.count !== e.count || o.ovf !== e.ovf) begin
                    n_fail++; $display("[TB] FAIL sat_window%0d: got %0d/%b expected %0d/%b", w, o.count, o.ovf, e.count, e.ovf);
                end
            end
        end
        e = exp16_q.pop_front();
        n_checks++;
        if (obs16_q.size() != 2) begin
            n_fail++; $display("[TB] FAIL sat_wide_results: got %0d expected 2", obs16_q.size());
        end else begin
            o = obs16_q[1];
            n_checks++;
            if (o.count !== e.count || o.ovf !== e.ovf) begin
                n_fail++; $display("[TB] FAIL sat_wide_quiet: got %0d/%b expected %0d/%b", o.count, o.ovf, e.count, e.ovf);
            end
        end
        enable_i = 1'b0;
        ticks(5);
    endtask

    task automatic test_boundaries();
        int   offs[3];
        logic [15:0] want[3];
        int   c0;
        int   endc;
        int   windows;
        int   idx;
        exp_t e;
        obs_t o;
        $display("[TB] test_boundaries");
        offs[0] = -1; offs[1] = 0; offs[2] = GATE - 1;
        want[0] = 16'd0; want[1] = 16'd1; want[2] = 16'd1;
        for (int r = 0; r < 3; r++) begin
            osc_period = 0;
            osc_level  = 1'b0;
            ticks(6);
            clear_queues();
            windows = (r == 2) ? 2 : 1;
            exp16_q.push_back('{want[r], 1'b0});
            if (windows == 2) exp16_q.push_back('{16'd0, 1'b0});
            c0   = cyc + 3;
            endc = c0 + GATE + 2 + GATE * (windows - 1) + 5;
            while (cyc < endc) begin
                idx = cyc + 1;
                osc_level = (idx >= c0 + offs[r] && idx < c0 + offs[r] + 4);
                tick();
                if (cyc == c0) enable_i = 1'b1;
            end
            enable_i = 1'b0;
            n_checks++;
            if (obs16_q.size() != windows) begin
                n_fail++; $display("[TB] FAIL boundary%0d_results: got %0d expected %0d", r, obs16_q.size(), windows);
            end else begin
                for (int w = 0; w < windows; w++) begin
                    e = exp16_q.pop_front();
                    o = obs16_q.pop_front();
                    n_checks++;
                    if (o.count !== e.count) begin
                        n_fail++; $display("[TB] FAIL boundary%0d_w%0d: got %0d expected %0d", r, w, o.count, e.count);
                    end
                end
            end
        end
        ticks(5);
    endtask

    task automatic test_abort();
        bit ok;
        obs_t o;
        int v;
        int r;
        $display("[TB] test_abort");
        clear_queues();
        osc_period = 10;
        osc_phase  = 0;
        ticks(2);
        enable_i = 1'b1;
        wait_obs16(150, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("[TB] FAIL abort_first_timeout: got no result expected one");
            v = cyc;
        end else begin
            o = obs16_q.pop_front();
            v = o.cyc;
            n_checks++;
            if (o.count !== 16'd10) begin n_fail++; $display("[TB] FAIL abort_first_count: got %0d expected 10", o.count); end
        end
        while (cyc < v + 51) tick();
        n_checks++;
        if (busy16 !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_busy_on: got %b expected 1", busy16); end
        enable_i = 1'b0;
        ticks(3);
        n_checks++;
        if (busy16 !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy_off: got %b expected 0", busy16); end
        ticks(150);
        n_checks++;
        if (obs16_q.size() != 0 || count16 !== 16'd10) begin
            n_fail++; $display("[TB] FAIL abort_hold: got results=%0d count=%0d expected 0/10", obs16_q.size(), count16);
        end
        enable_i = 1'b1;
        r = cyc;
        wait_obs16(150, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("[TB] FAIL abort_reenable_timeout: got no result expected one");
        end else begin
            o = obs16_q.pop_front();
            n_checks++;
            if (o.cyc != r + GATE + 2 || o.count !== 16'd10) begin
                n_fail++; $display("[TB] FAIL abort_reenable: got cycle %0d count %0d expected %0d/10", o.cyc, o.count, r + GATE + 2);
            end
        end
        enable_i = 1'b0;
        ticks(5);
    endtask

    task automatic test_reset_mid();
        bit ok;
        obs_t o;
        int c0;
        int q;
        $display("[TB] test_reset_mid");
        clear_queues();
        osc_period = 10;
        osc_phase  = 0;
        ticks(2);
        enable_i = 1'b1;
        c0 = cyc;
        while (cyc < c0 + 32) tick();
        n_checks++;
        if (busy16 !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_busy_on: got %b expected 1", busy16); end
        rstn_i = 1'b0;
        #1;
        n_checks++;
        if (count16 !== 16'd0 || busy16 !== 1'b0 || valid16 !== 1'b0 || ovf16 !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rmid_outputs: got c=%0d b=%b v=%b o=%b expected 0", count16, busy16, valid16, ovf16);
        end
        ticks(3);
        rstn_i = 1'b1;
        q = cyc;
        n_checks++;
        if (obs16_q.size() != 0) begin n_fail++; $display("[TB] FAIL rmid_no_valid: got %0d results expected 0", obs16_q.size()); end
        wait_obs16(150, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("[TB] FAIL rmid_timeout: got no result expected one");
        end else begin
            o = obs16_q.pop_front();
            n_checks++;
            if (o.cyc != q + GATE + 2 || o.count !== 16'd10 || o.ovf !== 1'b0) begin
                n_fail++; $display("[TB] FAIL rmid_result: got cycle %0d count %0d expected %0d/10", o.cyc, o.count, q + GATE + 2);
            end
        end
        enable_i = 1'b0;
        ticks(5);
    endtask

    task automatic test_static();
        bit ok;
        obs_t o;
        exp_t e;
        $display("[TB] test_static");
        clear_queues();
        osc_period = 0;
        osc_level  = 1'b1;
        ticks(10);
        enable_i = 1'b1;
        exp16_q.push_back('{16'd0, 1'b0});
        e = exp16_q.pop_front();
        wait_obs16(150, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("[TB] FAIL static_timeout: got no result expected one");
        end else begin
            o = obs16_q.pop_front();
            n_checks++;
            if (o.count !== e.count || o.ovf !== e.ovf) begin
                n_fail++; $display("[TB] FAIL static_count: got %0d/%b expected %0d/%b", o.count, o.ovf, e.count, e.ovf);
            end
        end
        enable_i  = 1'b0;
        osc_level = 1'b0;
        ticks(5);
    endtask

    initial begin
        rstn_i   = 1'b0;
        enable_i = 1'b0;
        osc_i    = 1'b0;
        test_reset();
        test_nominal();
        test_saturation();
        test_boundaries();
        test_abort();
        test_reset_mid();
        test_static();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
